npc_mem_arb: RTL and testbench

- Arbiter for the core's single memory port, shared by two requesters: instruction fetch (IFU, which supplies `inst` to the core) and the load/store unit (LSU).
- Exactly one transaction is in flight at a time.
- Default priority goes to LSU; a streak limit stops it from starving IFU.
- A response timeout turns a hung memory into an error response instead of a deadlocked core.

---
 rtl/npc_pkg.sv | 29 ++
 rtl/npc_mem_arb_prio.sv | 53 +++++
 rtl/npc_mem_arb.sv | 196 +++++++++++++++++++
 tb/tb_npc_mem_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC memory-port arbiter slice.
//   - Arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   - Owner encoding (which requester holds the memory port)
//   - Reset address constant shared with the PC logic
package npc_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_WAIT  = 2'd2;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic [31:0] RESET_ADDR = 32'h8000_0000;

    // Saturating increment for the 4-bit LSU streak counter.
    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] limit);
        logic [3:0] nxt;
        if (cur >= limit) begin
            nxt = limit;
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_mem_arb_prio.sv
// Winner selection for the shared memory port plus the LSU streak counter.
//   clk, global_rst_n : clock, async active-low reset
//   ifu_req, lsu_req  : raw requests from fetch and load/store
//   arb_en            : high in every IDLE cycle of the arbiter FSM
//   winner            : OWNER_LSU or OWNER_IFU; only meaningful when a request is present
// LSU has priority, but once it has won MAX_LSU_STREAK times in a row while
// fetch was waiting, fetch gets the next slot.
module npc_mem_arb_prio
    import npc_pkg::*;
#(
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input  logic clk,
    input  logic global_rst_n,
    input  logic ifu_req,
    input  logic lsu_req,
    input  logic arb_en,
    output logic winner
);

    localparam logic [3:0] STREAK_MAX_C = 4'(MAX_LSU_STREAK);

    logic [3:0] streak_r;
    logic       ifu_starved_s;

    // Winner decision: LSU first unless fetch has been starved long enough.
    always_comb begin
        ifu_starved_s = ifu_req && (streak_r == STREAK_MAX_C);
        if (lsu_req && !ifu_starved_s) begin
            winner = OWNER_LSU;
        end else begin
            winner = OWNER_IFU;
        end
    end

    // Streak counter: counts LSU wins that made fetch wait, cleared otherwise.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            streak_r <= 4'd0;
        end else if (arb_en) begin
            if (!ifu_req) begin
                streak_r <= 4'd0;
            end else if (winner == OWNER_LSU) begin
                streak_r <= streak_inc(streak_r, STREAK_MAX_C);
            end else begin
                streak_r <= 4'd0;
            end
        end else begin
            streak_r <= streak_r;
        end
    end

endmodule

// File: rtl/npc_mem_arb.sv
// Arbiter for the core's single memory port shared by fetch (IFU) and
// load/store (LSU). One transaction in flight; IDLE arbitrates, ISSUE
// presents the request until memory accepts it, WAIT holds until the
// response or a timeout, which is reported as an error response.
//   clk, global_rst_n          : clock, async active-low reset
//   ifu_req/addr -> gnt/rvalid/rdata/err : fetch requester
//   lsu_req/we/addr/wdata/wstrb -> gnt/rvalid/rdata/err : load/store requester
//   mem_req/we/addr/wdata/wstrb, mem_ready, mem_rvalid/rdata/err : memory side
//   busy                       : arbiter is not IDLE
// Grant and response are combinational pass-throughs so the minimum round
// trip is request at cycle 0, grant at cycle 1, response at cycle 2.
module npc_mem_arb
    import npc_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_LSU_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  ifu_req,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_err,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_err,
    output logic                  busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    // timer_r counts completed WAIT cycles, so the timeout fires in the
    // TIMEOUT_CYCLES-th WAIT cycle after the grant.
    localparam logic [15:0] TIMEOUT_LAST_C = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_r;
    logic              owner_r;
    logic [15:0]       timer_r;

    logic              winner_s;
    logic              arb_en_s;
    logic              owner_req_s;
    logic              accept_s;
    logic              timeout_s;
    logic              resp_valid_s;
    logic [DATA_W-1:0] resp_data_s;
    logic              resp_err_s;

    npc_mem_arb_prio #(
        .MAX_LSU_STREAK (MAX_LSU_STREAK)
    ) u_prio (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ifu_req      (ifu_req),
        .lsu_req      (lsu_req),
        .arb_en       (arb_en_s),
        .winner       (winner_s)
    );

    // Transaction status: acceptance, timeout and the response to forward.
    always_comb begin
        arb_en_s     = (state_r == ST_IDLE);
        owner_req_s  = (owner_r == OWNER_LSU) ? lsu_req : ifu_req;
        accept_s     = (state_r == ST_ISSUE) && owner_req_s && mem_ready;
        timeout_s    = (state_r == ST_WAIT) && (timer_r >= TIMEOUT_LAST_C);
        resp_valid_s = (state_r == ST_WAIT) && (mem_rvalid || timeout_s);
        resp_data_s  = {DATA_W{1'b0}};
        resp_err_s   = 1'b0;
        // A real response beats a timeout landing in the same cycle.
        if ((state_r == ST_WAIT) && mem_rvalid) begin
            resp_data_s = mem_rdata;
            resp_err_s  = mem_err;
        end else if (timeout_s) begin
            resp_data_s = {DATA_W{1'b0}};
            resp_err_s  = 1'b1;
        end else begin
            resp_data_s = {DATA_W{1'b0}};
            resp_err_s  = 1'b0;
        end
    end

    // Memory-side request mux: driven only while ISSUE, from the owner.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_wstrb = {STRB_W{1'b0}};
        if (state_r == ST_ISSUE) begin
            mem_req = owner_req_s;
            if (owner_r == OWNER_LSU) begin
                mem_we    = lsu_we;
                mem_addr  = lsu_addr;
                mem_wdata = lsu_wdata;
                mem_wstrb = lsu_wstrb;
            end else begin
                mem_we    = 1'b0;
                mem_addr  = ifu_addr;
                mem_wdata = {DATA_W{1'b0}};
                mem_wstrb = {STRB_W{1'b0}};
            end
        end else begin
            mem_req = 1'b0;
        end
    end

    // Requester-side routing: only the owner sees grant and response.
    always_comb begin
        ifu_gnt    = accept_s && (owner_r == OWNER_IFU);
        lsu_gnt    = accept_s && (owner_r == OWNER_LSU);
        ifu_rvalid = resp_valid_s && (owner_r == OWNER_IFU);
        lsu_rvalid = resp_valid_s && (owner_r == OWNER_LSU);
        ifu_rdata  = {DATA_W{1'b0}};
        ifu_err    = 1'b0;
        lsu_rdata  = {DATA_W{1'b0}};
        lsu_err    = 1'b0;
        if (ifu_rvalid) begin
            ifu_rdata = resp_data_s;
            ifu_err   = resp_err_s;
        end else begin
            ifu_rdata = {DATA_W{1'b0}};
            ifu_err   = 1'b0;
        end
        if (lsu_rvalid) begin
            lsu_rdata = resp_data_s;
            lsu_err   = resp_err_s;
        end else begin
            lsu_rdata = {DATA_W{1'b0}};
            lsu_err   = 1'b0;
        end
        busy = (state_r != ST_IDLE);
    end

    // Arbiter FSM with owner latch and WAIT timer.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= OWNER_IFU;
            timer_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ifu_req || lsu_req) begin
                        owner_r <= winner_s;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Owner withdrawing before the grant abandons the slot.
                    if (!owner_req_s) begin
                        state_r <= ST_IDLE;
                    end else if (mem_ready) begin
                        state_r <= ST_WAIT;
                        timer_r <= 16'd0;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    timer_r <= timer_r + 16'd1;
                    if (resp_valid_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    owner_r <= OWNER_IFU;
                    timer_r <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_mem_arb.sv
// Directed testbench for npc_mem_arb: a per-cycle vector table plus
// hand-written sequences for contention, timeout and reset mid-transaction.
module tb_npc_mem_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        global_rst_n;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt, ifu_rvalid, ifu_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req, lsu_we;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    npc_mem_arb #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_LSU_STREAK (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ifu_req      (ifu_req),
        .ifu_addr     (ifu_addr),
        .ifu_gnt      (ifu_gnt),
        .ifu_rvalid   (ifu_rvalid),
        .ifu_rdata    (ifu_rdata),
        .ifu_err      (ifu_err),
        .lsu_req      (lsu_req),
        .lsu_we       (lsu_we),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_wstrb    (lsu_wstrb),
        .lsu_gnt      (lsu_gnt),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rdata    (lsu_rdata),
        .lsu_err      (lsu_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err),
        .busy         (busy)
    );

    typedef struct packed {
        logic        ifu_req;
        logic [31:0] ifu_addr;
        logic        lsu_req;
        logic        lsu_we;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wstrb;
        logic        mem_ready;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        mem_err;
    } in_t;

    typedef struct packed {
        logic        ifu_gnt;
        logic        ifu_rvalid;
        logic [31:0] ifu_rdata;
        logic        ifu_err;
        logic        lsu_gnt;
        logic        lsu_rvalid;
        logic [31:0] lsu_rdata;
        logic        lsu_err;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic        busy;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;
    out_t zero_o;
    in_t  zero_i;

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic lr, logic lw,
                                  logic [31:0] la, logic [31:0] lwd, logic [3:0] ls,
                                  logic rdy, logic rv, logic [31:0] rd, logic er);
        in_t v;
        v.ifu_req = ir;  v.ifu_addr = ia;   v.lsu_req = lr;    v.lsu_we = lw;
        v.lsu_addr = la; v.lsu_wdata = lwd; v.lsu_wstrb = ls;  v.mem_ready = rdy;
        v.mem_rvalid = rv; v.mem_rdata = rd; v.mem_err = er;
        return v;
    endfunction

    function automatic out_t mk_out(logic ig, logic iv, logic [31:0] ird, logic ie,
                                    logic lg, logic lv, logic [31:0] lrd, logic le,
                                    logic mr, logic mw, logic [31:0] ma, logic [31:0] mwd,
                                    logic [3:0] ms, logic b);
        out_t v;
        v.ifu_gnt = ig; v.ifu_rvalid = iv; v.ifu_rdata = ird; v.ifu_err = ie;
        v.lsu_gnt = lg; v.lsu_rvalid = lv; v.lsu_rdata = lrd; v.lsu_err = le;
        v.mem_req = mr; v.mem_we = mw; v.mem_addr = ma; v.mem_wdata = mwd;
        v.mem_wstrb = ms; v.busy = b;
        return v;
    endfunction

    function automatic out_t cur_out();
        return mk_out(ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err, lsu_gnt, lsu_rvalid,
                      lsu_rdata, lsu_err, mem_req, mem_we, mem_addr, mem_wdata,
                      mem_wstrb, busy);
    endfunction

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n; v.i = i; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic apply(input in_t v);
        ifu_req = v.ifu_req;   ifu_addr = v.ifu_addr;   lsu_req = v.lsu_req;
        lsu_we = v.lsu_we;     lsu_addr = v.lsu_addr;   lsu_wdata = v.lsu_wdata;
        lsu_wstrb = v.lsu_wstrb; mem_ready = v.mem_ready; mem_rvalid = v.mem_rvalid;
        mem_rdata = v.mem_rdata; mem_err = v.mem_err;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input out_t exp);
        out_t act;
        act = cur_out();
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: outputs got %h required %h", nm, act, exp);
    endtask

    task automatic chk_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    localparam logic [31:0] A0 = 32'h8000_0000;

    initial begin
        logic exp_lsu [7];
        int   ng;
        logic pend;
        int   k_hit;

        zero_o = '0;
        zero_i = '0;
        exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // ---- reset with both requesters asking: every output must be 0
        global_rst_n = 1'b0;
        apply(zero_i);
        ifu_req = 1'b1;
        lsu_req = 1'b1;
        #12;
        chk_out("reset_state", zero_o);
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        next_cycle();
        global_rst_n = 1'b1;

        // ---- vector table, one entry per clock cycle
        add("idle_ifu",   mk_in(1'b1, A0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0), zero_o);
        add("ifu_issue",  mk_in(1'b1, A0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, A0, 32'h0, 4'h0, 1'b1));
        add("ifu_resp",   mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h13, 1'b0),
                          mk_out(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("st_arb",     mk_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0, 32'h0, 1'b0), zero_o);
        add("st_issue",   mk_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1));
        add("st_ack",     mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("stall_arb",  mk_in(1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0), zero_o);
        add("stall_1",    mk_in(1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1));
        add("stall_2_rv", mk_in(1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h55, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1));
        add("stall_3",    mk_in(1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1));
        add("stall_gnt",  mk_in(1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1));
        add("err_resp",   mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1),
                          mk_out(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("drop_arb",   mk_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_2000, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0), zero_o);
        add("drop_issue", mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("drop_idle",  mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h77, 1'b1), zero_o);
        add("ld_arb",     mk_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0), zero_o);
        add("ld_issue",   mk_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, 1'b1));
        add("ld_wait",    mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("ld_resp",    mk_in(1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0),
                          mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("b2b_arb",    mk_in(1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0), zero_o);
        add("b2b_issue",  mk_in(1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0),
                          mk_out(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 1'b1));
        add("b2b_resp",   mk_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h93, 1'b0),
                          mk_out(1'b0, 1'b1, 32'h93, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        add("idle_end",   zero_i, zero_o);

        foreach (vecs[n]) begin
            next_cycle();
            apply(vecs[n].i);
            #3;
            chk_out(vecs[n].name, vecs[n].o);
        end

        // ---- contention: both held high, expect L L L L I L L
        ng = 0;
        pend = 1'b0;
        for (int c = 0; c < 80 && ng < 7; c++) begin
            next_cycle();
            apply(zero_i);
            ifu_req = 1'b1;  ifu_addr = 32'h8000_0010;
            lsu_req = 1'b1;  lsu_addr = 32'h8000_0200;
            mem_ready = 1'b1;
            mem_rvalid = pend;
            pend = 1'b0;
            #3;
            if (ifu_gnt || lsu_gnt) begin
                chk_word($sformatf("grant_order_%0d", ng), {31'd0, lsu_gnt}, {31'd0, exp_lsu[ng]});
                chk_word($sformatf("grant_onehot_%0d", ng), {31'd0, ifu_gnt & lsu_gnt}, 32'd0);
                ng++;
                pend = 1'b1;
            end
        end
        if (ng < 7) begin
            checks++;
            $display("FAIL contention_budget: got %0d grants required 7", ng);
        end
        next_cycle();
        apply(zero_i);
        mem_rvalid = pend;
        #3;
        next_cycle();
        apply(zero_i);
        #3;
        chk_out("contention_idle", zero_o);

        // ---- timeout: memory never answers, error response in WAIT cycle TO
        next_cycle();
        apply(zero_i); ifu_req = 1'b1; ifu_addr = 32'h8000_0020;
        #3;
        next_cycle();
        apply(zero_i); ifu_req = 1'b1; ifu_addr = 32'h8000_0020; mem_ready = 1'b1;
        #3;
        chk_word("to_gnt", {31'd0, ifu_gnt}, 32'd1);
        k_hit = 0;
        for (int k = 1; k <= TO + 4 && k_hit == 0; k++) begin
            next_cycle();
            apply(zero_i);
            #3;
            if (ifu_rvalid || lsu_rvalid) begin
                k_hit = k;
                chk_out("to_err_resp", mk_out(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
                                              1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
            end
        end
        chk_word("to_latency", 32'(k_hit), 32'(TO));
        next_cycle();
        apply(zero_i); mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        #3;
        chk_out("to_late_rvalid", zero_o);

        // ---- response on the same cycle as the timeout: real data wins
        next_cycle();
        apply(zero_i); lsu_req = 1'b1; lsu_addr = 32'h8000_0300;
        #3;
        next_cycle();
        apply(zero_i); lsu_req = 1'b1; lsu_addr = 32'h8000_0300; mem_ready = 1'b1;
        #3;
        chk_word("co_gnt", {31'd0, lsu_gnt}, 32'd1);
        for (int k = 1; k < TO; k++) begin
            next_cycle();
            apply(zero_i);
            #3;
            chk_word($sformatf("co_quiet_%0d", k), {31'd0, lsu_rvalid}, 32'd0);
        end
        next_cycle();
        apply(zero_i); mem_rvalid = 1'b1; mem_rdata = 32'h0000_CAFE;
        #3;
        chk_out("co_real_wins", mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_CAFE, 1'b0,
                                       1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1));
        next_cycle();
        apply(zero_i);
        #3;
        chk_out("co_idle", zero_o);

        // ---- asynchronous reset in WAIT: outputs drop at once, nothing stale after
        next_cycle();
        apply(zero_i); ifu_req = 1'b1; ifu_addr = 32'h8000_0040;
        #3;
        next_cycle();
        apply(zero_i); ifu_req = 1'b1; ifu_addr = 32'h8000_0040; mem_ready = 1'b1;
        #3;
        chk_word("rst_gnt", {31'd0, ifu_gnt}, 32'd1);
        next_cycle();
        apply(zero_i);
        #1;
        chk_word("rst_busy_before", {31'd0, busy}, 32'd1);
        #1;
        global_rst_n = 1'b0;
        #1;
        chk_out("rst_async", zero_o);
        next_cycle();
        apply(zero_i);
        #3;
        global_rst_n = 1'b1;
        next_cycle();
        apply(zero_i); mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #3;
        chk_out("rst_no_stale", zero_o);
        next_cycle();
        apply(zero_i);
        #3;
        chk_out("rst_idle", zero_o);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
